// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: PC-1/PC-2 tables, shift table and FSM states.
// The optional decrypt path in des_key_schedule is enabled by DES_KS_DECRYPT_EN.
package des_pkg;

   localparam int unsigned KEY_W  = 64;
   localparam int unsigned CD_W   = 56;
   localparam int unsigned HALF_W = 28;
   localparam int unsigned KN_W   = 48;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } ks_state_t;

   // PC-1: entry i gives the key bit (1 = MSB) that lands in C/D bit i+1
   localparam int unsigned PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   // PC-2: entry i gives the C/D bit that lands in subkey bit i+1
   localparam int unsigned PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Shift table s(n): bit n set means s(n) = 2, clear means s(n) = 1 (bit 0 unused)
   localparam logic [16:0] SHIFT_TWO = 17'b0_1111_1101_1111_1000;

   function automatic logic shift_two(input logic [4:0] n);
      return SHIFT_TWO[n];
   endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 permutation: 56-bit {C,D} to 48-bit round subkey.
module des_pc2
   import des_pkg::*;
(
   input  logic [1:CD_W] cd,
   output logic [1:KN_W] kn
);

   for (genvar g = 0; g < 48; g++) begin : g_pc2
      assign kn[g+1] = cd[PC2_TAB[g]];
   end

   // Bits 9,18,22,25,35,38,43,54 are dropped by PC-2
   logic unused_cd;
   assign unused_cd = ^{cd[9], cd[18], cd[22], cd[25], cd[35], cd[38], cd[43], cd[54]};

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: delivers K1..K16 one per valid/next handshake.
// Define DES_KS_DECRYPT_EN to add the decrypt port and K16..K1 ordering.
module des_key_schedule
   import des_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [1:KEY_W] key,
`ifdef DES_KS_DECRYPT_EN
   input  logic           decrypt,
`endif
   input  logic           next,
   output logic           kn_valid,
   output logic [1:KN_W]  Kn,
   output logic [4:0]     kn_index,
   output logic           done
);

   ks_state_t       state;
   logic [1:HALF_W] c, d;
   logic [3:0]      rnd;     // holds n-1 so rounds 1..16 fit in four bits
   logic [1:CD_W]   pc1_key;
   logic [1:HALF_W] c_load, d_load, c_step, d_step;
   logic [4:0]      idx_load, idx_step;

   function automatic logic [1:HALF_W] rotl(input logic [1:HALF_W] v, input logic two);
      return two ? {v[3:HALF_W], v[1:2]} : {v[2:HALF_W], v[1]};
   endfunction

   // PC-1 selection of the 56 key bits
   for (genvar g = 0; g < 56; g++) begin : g_pc1
      assign pc1_key[g+1] = key[PC1_TAB[g]];
   end

   // Parity bits do not take part in the schedule
   logic unused_parity;
   assign unused_parity = ^{key[8], key[16], key[24], key[32], key[40], key[48], key[56], key[64]};

`ifdef DES_KS_DECRYPT_EN
   logic dec_q;

   function automatic logic [1:HALF_W] rotr(input logic [1:HALF_W] v, input logic two);
      return two ? {v[HALF_W-1:HALF_W], v[1:HALF_W-2]} : {v[HALF_W], v[1:HALF_W-1]};
   endfunction

   // Direction is captured only with an accepted load
   always_ff @(posedge clk) begin
      if (rst)                          dec_q <= 1'b0;
      else if (state == ST_IDLE && start) dec_q <= decrypt;
   end

   // Decrypt starts from C0/D0 (== C16/D16) and walks the shifts backwards
   assign c_load   = decrypt ? pc1_key[1:HALF_W]      : rotl(pc1_key[1:HALF_W], shift_two(5'd1));
   assign d_load   = decrypt ? pc1_key[HALF_W+1:CD_W] : rotl(pc1_key[HALF_W+1:CD_W], shift_two(5'd1));
   assign idx_load = decrypt ? 5'd16 : 5'd1;
   assign c_step   = dec_q ? rotr(c, shift_two(5'd16 - 5'(rnd))) : rotl(c, shift_two(5'(rnd) + 5'd2));
   assign d_step   = dec_q ? rotr(d, shift_two(5'd16 - 5'(rnd))) : rotl(d, shift_two(5'(rnd) + 5'd2));
   assign idx_step = dec_q ? (5'd15 - 5'(rnd)) : (5'(rnd) + 5'd2);
`else
   // Encrypt-only load and advance
   assign c_load   = rotl(pc1_key[1:HALF_W], shift_two(5'd1));
   assign d_load   = rotl(pc1_key[HALF_W+1:CD_W], shift_two(5'd1));
   assign idx_load = 5'd1;
   assign c_step   = rotl(c, shift_two(5'(rnd) + 5'd2));
   assign d_step   = rotl(d, shift_two(5'(rnd) + 5'd2));
   assign idx_step = 5'(rnd) + 5'd2;
`endif

   // Schedule FSM with registered handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         c        <= '0;
         d        <= '0;
         rnd      <= '0;
         kn_valid <= 1'b0;
         kn_index <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  c        <= c_load;
                  d        <= d_load;
                  rnd      <= '0;
                  kn_valid <= 1'b1;
                  kn_index <= idx_load;
                  state    <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (next) begin
                  if (rnd == 4'd15) begin
                     kn_valid <= 1'b0;
                     kn_index <= '0;
                     done     <= 1'b1;
                     state    <= ST_DONE;
                  end else begin
                     c        <= c_step;
                     d        <= d_step;
                     rnd      <= rnd + 4'd1;
                     kn_index <= idx_step;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   des_pc2 u_pc2 (
      .cd ({c, d}),
      .kn (Kn)
   );

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: subkey table plus scoreboard queue.
module tb_des_key_schedule;

   localparam logic [63:0] KEY = 64'h133457799BBCDFF1;

   typedef struct {
      logic [4:0]  idx;
      logic [47:0] kn;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] key;
`ifdef DES_KS_DECRYPT_EN
   logic        decrypt;
`endif
   logic        next;
   logic        kn_valid;
   logic [47:0] kn;
   logic [4:0]  kn_index;
   logic        done;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs [16];
   vec_t sb [$];

   always #5 clk = ~clk;

   des_key_schedule dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key      (key),
`ifdef DES_KS_DECRYPT_EN
      .decrypt  (decrypt),
`endif
      .next     (next),
      .kn_valid (kn_valid),
      .Kn       (kn),
      .kn_index (kn_index),
      .done     (done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_kn_valid"}, 64'(kn_valid), 64'd0);
      chk({tag, "_done"},     64'(done),     64'd0);
      chk({tag, "_kn_index"}, 64'(kn_index), 64'd0);
      chk({tag, "_Kn"},       64'(kn),       64'd0);
   endtask

   // Load the key, then walk the schedule with random next gaps up to max_gap.
   // poke pulses start at index 5; rst_at asserts reset when that index is shown.
   task automatic run_sched(input bit dec, input int max_gap, input bit poke, input int rst_at);
      int ticks;
      int guard;
      int gap;
      bit nx;
      sb.delete();
      for (int i = 0; i < 16; i++) sb.push_back(dec ? vecs[15-i] : vecs[i]);
      start = 1'b1;
      key   = KEY;
      next  = (max_gap == 0);
`ifdef DES_KS_DECRYPT_EN
      decrypt = dec;
`endif
      tick();
      ticks = 1;
      start = 1'b0;
      key   = {$urandom, $urandom};
`ifdef DES_KS_DECRYPT_EN
      decrypt = !dec;
`endif
      gap   = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      guard = 0;
      while (sb.size() > 0 && guard < 200) begin
         chk("kn_valid", 64'(kn_valid), 64'd1);
         chk("Kn",       64'(kn),       64'(sb[0].kn));
         chk("kn_index", 64'(kn_index), 64'(sb[0].idx));
         if (rst_at == int'(sb[0].idx)) begin
            rst   = 1'b1;
            next  = 1'b0;
            tick();
            rst   = 1'b0;
            chk_reset_outputs("mid_rst");
            sb.delete();
            return;
         end
         if (gap > 0) begin
            nx = 1'b0;
            gap--;
         end else begin
            nx  = 1'b1;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         end
         next  = nx;
         start = poke && (sb[0].idx == 5'd5);
         key   = {$urandom, $urandom};
         tick();
         ticks++;
         guard++;
         if (nx) void'(sb.pop_front());
      end
      start = 1'b0;
      chk("schedule_remaining", 64'(sb.size()), 64'd0);
      chk("done_pulse",     64'(done),     64'd1);
      chk("done_kn_valid",  64'(kn_valid), 64'd0);
      chk("done_kn_index",  64'(kn_index), 64'd0);
      if (max_gap == 0) chk("start_to_done", 64'(ticks), 64'd17);
      tick();
      chk("done_one_cycle", 64'(done),     64'd0);
      chk("idle_kn_valid",  64'(kn_valid), 64'd0);
      next = 1'b0;
      tick();
      chk("idle_stays",     64'(kn_valid), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{5'd1,  48'h1B02EFFC7072};
      vecs[1]  = '{5'd2,  48'h79AED9DBC9E5};
      vecs[2]  = '{5'd3,  48'h55FC8A42CF99};
      vecs[3]  = '{5'd4,  48'h72ADD6DB351D};
      vecs[4]  = '{5'd5,  48'h7CEC07EB53A8};
      vecs[5]  = '{5'd6,  48'h63A53E507B2F};
      vecs[6]  = '{5'd7,  48'hEC84B7F618BC};
      vecs[7]  = '{5'd8,  48'hF78A3AC13BFB};
      vecs[8]  = '{5'd9,  48'hE0DBEBEDE781};
      vecs[9]  = '{5'd10, 48'hB1F347BA464F};
      vecs[10] = '{5'd11, 48'h215FD3DED386};
      vecs[11] = '{5'd12, 48'h7571F59467E9};
      vecs[12] = '{5'd13, 48'h97C5D1FABA41};
      vecs[13] = '{5'd14, 48'h5F43B7F2E73A};
      vecs[14] = '{5'd15, 48'hBF918D3D3F0A};
      vecs[15] = '{5'd16, 48'hCB3D8B0E17F5};

      rst   = 1'b1;
      start = 1'b0;
      next  = 1'b0;
      key   = '0;
`ifdef DES_KS_DECRYPT_EN
      decrypt = 1'b0;
`endif
      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick();
      chk_reset_outputs("idle_after_reset");

      run_sched(1'b0, 0, 1'b0, -1);   // next held high, start+next together
      run_sched(1'b0, 5, 1'b0, -1);   // random stalls
      run_sched(1'b0, 2, 1'b1, -1);   // start poked in round 5
      run_sched(1'b0, 1, 1'b0, 8);    // reset at index 8
      run_sched(1'b0, 0, 1'b0, -1);   // fresh load after reset
`ifdef DES_KS_DECRYPT_EN
      run_sched(1'b1, 0, 1'b0, -1);
      run_sched(1'b1, 4, 1'b0, -1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard stop if the stimulus process ever stalls
   initial begin
      #500000;
      $display("FAIL watchdog expired at time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Generates the sixteen 48-bit DES round subkeys Kn from a 64-bit key and delivers them one at a time to the round-function stage. It sits directly upstream of `des_roundfunction` and drives its `Kn` input. Delivery uses a valid/next handshake so the consumer paces subkey delivery. Subkey order is K1..K16 (encrypt) or K16..K1 (decrypt, when compiled in).

## Interface
Parameters: none.

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to load `key`; honoured only in IDLE
- `key`  in  [1:64]  DES key, bit 1 = MSB; parity bits 8,16,…,64 ignored
- `decrypt`  in  1  present only with `DES_KS_DECRYPT_EN`; sampled with `start`
- `next`  in  1  consumer acknowledge; advances to the next subkey when `kn_valid` is high
- `kn_valid`  out  1  `Kn` holds a valid subkey
- `Kn`  out  [1:48]  current subkey = PC-2(C,D), combinational from the C/D registers
- `kn_index`  out  5  index n of the subkey on `Kn` (1..16); 0 when not valid
- `done`  out  1  one-cycle pulse after the 16th subkey is acknowledged

## Operation
- State: C, D (28 bits each), 4-bit round counter, FSM {IDLE, ROUND, DONE}.
- Shift table s(n): 1 for n = 1, 2, 9, 16; 2 otherwise. Total over 16 rounds = 28.
- IDLE, `start`=1, encrypt:
  - (C,D) ← PC-1(key), each half rotated left by s(1).
  - Counter ← 1; go to ROUND.
- IDLE, `start`=1, decrypt:
  - (C,D) ← PC-1(key), unrotated, since C16 = C0.
  - Counter ← 1; go to ROUND.
- ROUND:
  - `kn_valid`=1.
  - `kn_index` = counter (encrypt) or 17−counter (decrypt).
- ROUND, `next`=1, counter < 16:
  - Encrypt: rotate C,D left by s(counter+1).
  - Decrypt: rotate C,D right by s(17−counter).
  - Counter +1.
- ROUND, `next`=1, counter = 16: go to DONE; C/D unchanged.
- DONE: `done`=1 and `kn_valid`=0 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. `next` outside ROUND is ignored.
- `start` and `next` in the same IDLE cycle: `start` wins and `next` is ignored.
- `key` and `decrypt` are sampled only on the accepted `start` cycle. Later changes have no effect until the next load.

## Timing
- Reset values: C=D=0, counter=0, FSM=IDLE, `kn_valid`=0, `done`=0, `kn_index`=0, `Kn`=48'h0.
- `rst` is synchronous and overrides everything, including mid-schedule. The cycle after `rst`, the block is in IDLE with all outputs at reset values.
- Latency: `start` accepted at edge t → `kn_valid`=1 with the first subkey from edge t+1.
- `next` high at edge t → the following subkey is visible after edge t.
- `next` held high continuously yields one subkey per cycle. The full schedule then takes 16 ROUND cycles plus 1 DONE cycle; `start`→`done` is 17 cycles.
- `Kn` is stable while `kn_valid`=1 and `next`=0, with no timeout.

## Configuration
- `DES_KS_DECRYPT_EN` defined:
  - `decrypt` port exists.
  - Right-rotate path and reverse `kn_index` mapping are built.
- `DES_KS_DECRYPT_EN` not defined:
  - No `decrypt` port; encrypt order only.
  - Right-rotate logic is absent.

## Structure
- Shared package `des_pkg` holds:
  - PC-1 and PC-2 permutation tables.
  - Shift table s(1..16).
  - FSM state encoding constants.
- One sub-module, `des_pc2`: purely combinational 56→48 permutation instantiated for `Kn`. PC-1 and the rotates stay inline.

## Test plan
All scenarios use key 64'h133457799BBCDFF1.

- Encrypt, `next` held high:
  - K1 = 48'h1B02EFFC7072 (`kn_index`=1).
  - K2 = 48'h79AED9DBC9E5.
  - K16 = 48'hCB3D8B0E17F5.
  - `done` pulses exactly 17 cycles after `start`.
- Decrypt (`DES_KS_DECRYPT_EN`):
  - First subkey is 48'hCB3D8B0E17F5 with `kn_index`=16.
  - Last subkey is 48'h1B02EFFC7072 with `kn_index`=1.
- Stalls: random `next` gaps of 0–5 cycles → `Kn` constant during each stall; same 16-subkey sequence as the unstalled run.
- `start` pulsed while in ROUND at round 5 → ignored; the sequence continues to K16 with no reload.
- `rst` asserted at `kn_index`=8 → next cycle all outputs at reset values. A fresh `start` then produces K1 = 48'h1B02EFFC7072.
- Drive all 16 subkeys into `des_roundfunction` with L/R = IP(64'h0123456789ABCDEF) → final swapped output after IP⁻¹ = 64'h85E813540F0AB405.
